fabric_config_loader: RTL and testbench
=======================================

// Module: fabric_config_loader
// PURPOSE
//  Upstream programming stage for the FU/switchbox grid. Accepts one config word per
//  grid cell over a valid/ready stream, fills a shadow store in row-major order, then
//  commits atomically to active registers driving every FU mode and switchbox select.
//  The fabric never sees a partially loaded configuration.
// PARAMETERS
//  NUM_ROWS    types::NUM_FU_ROWS (4)  grid rows
//  NUM_COLS    types::NUM_FU_COLS (4)  grid columns
//  (localparam) CFG_W = 3 + 2*types::FU_COLS_BITS (7)  config word width
//  (localparam) NUM_CELLS = NUM_ROWS*NUM_COLS (16)
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous, active-high reset
//  start      in   1      pulse: begin a load (honoured only in IDLE)
//  abort      in   1      discard in-progress load, return to IDLE
//  cfg_valid  in   1      word present on cfg_data
//  cfg_data   in   CFG_W  {mode[2:0], a_sel, b_sel}, packed as sb/fu structs
//  cfg_ready  out  1      loader accepts word this cycle
//  fu_prog    out  [NUM_ROWS][NUM_COLS] fu_program_data_t       active FU modes
//  sb_prog    out  [NUM_ROWS][NUM_COLS] sb_program_data_t       active switchbox sels
//  busy       out  1      state != IDLE
//  cfg_done   out  1      one-cycle pulse, first cycle new config is visible
//  cfg_err    out  1      sticky checksum failure (CFG_CHECKSUM_EN only, else 0)
// BEHAVIOUR
//  Reset: state=IDLE; fu_prog all a_add (0), sb_prog all 0; shadow and counter 0;
//   cfg_ready=0, busy=0, cfg_done=0, cfg_err=0. Reset mid-load discards the load and
//   clears active config.
//  FSM: IDLE -start-> LOAD -last word-> [CHECK] -> COMMIT -> IDLE.
//  IDLE: cfg_ready=0; cfg_valid ignored; start clears index to 0, clears cfg_err.
//  LOAD: cfg_ready=1. Accept = cfg_valid & cfg_ready. Word k -> shadow cell
//   row=k/NUM_COLS, col=k%NUM_COLS. Index increments per accept only; valid low = stall,
//   no timeout. Accept at k=NUM_CELLS-1 -> CHECK (if enabled) else COMMIT.
//  COMMIT: cfg_ready=0, one cycle; active <= shadow on its closing edge; cfg_done high
//   exactly the following cycle (state back in IDLE). Start→done latency with no
//   stalls = NUM_CELLS+2 cycles (+1 with checksum).
//  abort in LOAD/CHECK: back to IDLE next edge, word in that cycle not accepted, active
//   config unchanged, no cfg_done. abort in IDLE/COMMIT ignored (commit completes).
//  start while busy ignored. start & abort same cycle in IDLE: start wins.
//  Active registers change only on COMMIT edge or reset; stable at all other times.
//  No width arithmetic beyond index counter ($clog2(NUM_CELLS)+1 bits, no wrap).
// CONFIGURATION
//  CFG_CHECKSUM_EN defined: after NUM_CELLS words, CHECK state keeps cfg_ready=1 and
//   accepts one extra word; if its low CFG_W bits equal XOR of all NUM_CELLS words ->
//   COMMIT, else -> IDLE with cfg_err=1 (sticky until next start or rst), no commit,
//   no cfg_done.
//  Undefined: CHECK state absent, cfg_err tied 0, commit follows last word directly.
// TESTING
//  1 Reset then 16 words word_k=k, valid held high -> cfg_ready high 16 cycles, cfg_done
//    at start+18; fu_prog[1][2].mode=0, sb_prog[1][2]={a_sel=1,b_sel=2}; cell[3][3]=
//    {mode=0,a=3,b=3}.
//  2 Load all words 7'h7F with cfg_valid toggling every other cycle -> only valid
//    beats counted; every fu_prog=l_not, sels=3; done after 32+2 cycles.
//  3 After test 1, start, 5 words, abort -> busy falls next cycle, no cfg_done,
//    fu_prog/sb_prog still equal test 1 values; cfg_valid in IDLE gives cfg_ready=0.
//  4 start pulsed at word 3 of a load, and in COMMIT -> ignored; load of 16 completes.
//  5 CFG_CHECKSUM_EN, words k, checksum 7'h00 (XOR 0..15) -> commit+cfg_done; repeat
//    with checksum 7'h01 -> cfg_err=1, no cfg_done, active unchanged; next start clears
//    cfg_err.
//  6 rst asserted at word 8 of a load -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/fabric_config_loader.sv
// fabric_config_loader: streams one word per grid cell into a shadow store, then commits it atomically to the active FU/switchbox config
// Optional checksum word after the last cell when CFG_CHECKSUM_EN is defined
module fabric_config_loader #(
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 4,
  localparam int SEL_W = $clog2(NUM_COLS),
  localparam int CFG_W = 3 + 2 * SEL_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic cfg_valid,
  input  logic [CFG_W-1:0] cfg_data,
  output logic cfg_ready,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][2:0] fu_prog,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][2*SEL_W-1:0] sb_prog,
  output logic busy,
  output logic cfg_done,
  output logic cfg_err
);
  localparam int NUM_CELLS = NUM_ROWS * NUM_COLS;
  localparam int IW = $clog2(NUM_CELLS) + 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_CELLS - 1);
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
`ifdef CFG_CHECKSUM_EN
    CHECK,
`endif
    COMMIT
  } state_t;
`ifdef CFG_CHECKSUM_EN
  localparam state_t POST_LOAD = CHECK;
`else
  localparam state_t POST_LOAD = COMMIT;
`endif
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic [CFG_W-1:0] shadow [NUM_CELLS];
  logic [CFG_W-1:0] active [NUM_CELLS];
  logic acc, done;
`ifdef CFG_CHECKSUM_EN
  logic [CFG_W-1:0] csum;
  logic err;
  assign cfg_ready = state == LOAD || state == CHECK;
`else
  assign cfg_ready = state == LOAD;
`endif
  // abort wins over a coincident beat so a cancelled load never touches the shadow
  assign acc = cfg_valid & cfg_ready & ~abort;
  assign busy = state != IDLE;
  assign cfg_done = done;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = abort ? IDLE : (acc && idx == LAST) ? POST_LOAD : LOAD;
`ifdef CFG_CHECKSUM_EN
      CHECK:   nxt = abort ? IDLE : !acc ? CHECK : (cfg_data == csum) ? COMMIT : IDLE;
`endif
      COMMIT:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      done <= 1'b0;
      for (int i = 0; i < NUM_CELLS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      state <= nxt;
      done <= state == COMMIT;
      if (state == IDLE && start) idx <= '0;
      if (state == LOAD && acc) begin
        shadow[idx[IW-2:0]] <= cfg_data;
        idx <= idx + IW'(1);
      end
      if (state == COMMIT) active <= shadow;
    end
  end
`ifdef CFG_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
      err <= 1'b0;
    end else if (state == IDLE && start) begin
      csum <= '0;
      err <= 1'b0;
    end else if (state == LOAD && acc) csum <= csum ^ cfg_data;
    else if (state == CHECK && acc && cfg_data != csum) err <= 1'b1;
  end
  assign cfg_err = err;
`else
  assign cfg_err = 1'b0;
`endif
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_r
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_c
      assign {fu_prog[r][c], sb_prog[r][c]} = active[r*NUM_COLS+c];
    end
  end
endmodule

// File: tb/tb_fabric_config_loader.sv
// tb_fabric_config_loader: vector table, hand sequences and random loads against a cell-array reference model
module tb_fabric_config_loader;
  localparam int R = 4, C = 4, N = 16, W = 7;
`ifdef CFG_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  logic clk = 0, rst = 1, start = 0, abort = 0, cfg_valid = 0;
  logic [W-1:0] cfg_data = '0;
  logic cfg_ready, busy, cfg_done, cfg_err;
  logic [R-1:0][C-1:0][2:0] fu_prog;
  logic [R-1:0][C-1:0][3:0] sb_prog;
  int vectors = 0, errors = 0, cyc = 0;
  logic [W-1:0] exp_act [N];
  typedef struct {
    logic [W-1:0] base, step;
    bit gap;
    int abort_k, restart_k;
    bit bad;
  } vec_t;
  vec_t tbl [8];

  fabric_config_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .fu_prog(fu_prog), .sb_prog(sb_prog),
    .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_active(input string name);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s cell%0d", name, i), 32'({fu_prog[i/C][i%C], sb_prog[i/C][i%C]}), 32'(exp_act[i]));
  endtask

  task automatic chk_stable(input string name);
    int bad = 0;
    for (int i = 0; i < N; i++)
      if ({fu_prog[i/C][i%C], sb_prog[i/C][i%C]} !== exp_act[i]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic chk_reset(input string name);
    chk({name, " ready"}, 32'(cfg_ready), 0);
    chk({name, " busy"}, 32'(busy), 0);
    chk({name, " done"}, 32'(cfg_done), 0);
    chk({name, " err"}, 32'(cfg_err), 0);
    for (int i = 0; i < N; i++) exp_act[i] = '0;
    chk_active(name);
  endtask

  task automatic do_load(input logic [W-1:0] w [N], input bit gap, input int abort_k,
                         input int restart_k, input bit bad, output int lat);
    int s0, k = 0, last = 0, guard = 0, t = 0;
    bit ab = 0;
    logic [W-1:0] x = '0;
    lat = -1;
    @(negedge clk);
    start = 1;
    s0 = cyc;
    @(negedge clk);
    start = 0;
    chk("busy after start", 32'(busy), 1);
    chk("err cleared by start", 32'(cfg_err), 0);
    while (k < N && !ab && guard < 200) begin
      cfg_valid = gap ? ((cyc - s0) % 2 == 0) : 1'b1;
      cfg_data = cfg_valid ? w[k] : W'($urandom);
      abort = (k == abort_k) && cfg_valid;
      start = (k == restart_k);
      #1;
      chk("ready in LOAD", 32'(cfg_ready), 1);
      chk_stable("active stable during load");
      @(negedge clk);
      if (abort) ab = 1;
      else if (cfg_valid) begin
        x ^= w[k];
        k++;
        last = cyc - 1 - s0;
      end
      guard++;
    end
    {abort, start, cfg_valid} = '0;
    if (guard >= 200) chk("load cycle budget", 0, 1);
    if (ab) begin
      chk("busy after abort", 32'(busy), 0);
      repeat (3) begin
        chk("no done after abort", 32'(cfg_done), 0);
        chk_stable("active kept after abort");
        @(negedge clk);
      end
      return;
    end
`ifdef CFG_CHECKSUM_EN
    cfg_valid = 1;
    cfg_data = bad ? x ^ W'(1) : x;
    #1 chk("ready in CHECK", 32'(cfg_ready), 1);
    @(negedge clk);
    cfg_valid = 0;
    last = cyc - 1 - s0;
    if (bad) begin
      chk("busy after bad sum", 32'(busy), 0);
      repeat (3) begin
        chk("err sticky", 32'(cfg_err), 1);
        chk("no done after bad sum", 32'(cfg_done), 0);
        chk_stable("active kept after bad sum");
        @(negedge clk);
      end
      return;
    end
`endif
    while (!cfg_done && t < 40) begin
      start = (restart_k == N) && (cyc - s0 == last + 1);
      chk_stable("active stable before commit");
      @(negedge clk);
      t++;
    end
    start = 0;
    chk("done seen", 32'(cfg_done), 1);
    chk("done latency", 32'(cyc - s0), 32'(last + 2));
    lat = cyc - s0;
    for (int i = 0; i < N; i++) exp_act[i] = w[i];
    chk_active("committed");
    @(negedge clk);
    chk("done is one pulse", 32'(cfg_done), 0);
    chk("idle after commit", 32'(busy), 0);
  endtask

  initial begin
    logic [W-1:0] w [N];
    int lat;
    repeat (3) @(negedge clk);
    chk_reset("in reset");
    rst = 0;
    cfg_valid = 1;
    cfg_data = 7'h55;
    @(negedge clk);
    chk_reset("after reset");
    #1 chk("ready ignores valid in IDLE", 32'(cfg_ready), 0);
    cfg_valid = 0;

    for (int i = 0; i < N; i++) w[i] = W'(i);
    do_load(w, 0, -1, -1, 0, lat);
    chk("test1 latency", 32'(lat), 32'(N + 2 + CK));
    chk("cell12 mode", 32'(fu_prog[1][2]), 0);
    chk("cell12 sels", 32'(sb_prog[1][2]), 32'h6);
    chk("cell33", 32'({fu_prog[3][3], sb_prog[3][3]}), 32'h0F);

    for (int i = 0; i < N; i++) w[i] = 7'h7F;
    do_load(w, 1, -1, -1, 0, lat);
    chk("test2 latency", 32'(lat), 32'(2 * N + 2 + CK));
    chk("test2 mode l_not", 32'(fu_prog[2][1]), 7);

    tbl[0] = '{7'd0,  7'd1, 0, -1, -1, 0};
    tbl[1] = '{7'h11, 7'd3, 0,  5, -1, 0};
    tbl[2] = '{7'h20, 7'd5, 1, -1,  3, 0};
    tbl[3] = '{7'h40, 7'd7, 0, -1,  N, 0};
    tbl[4] = '{7'd0,  7'd1, 0, -1, -1, 1};
    tbl[5] = '{7'h09, 7'd9, 1,  0, -1, 0};
    tbl[6] = '{7'h33, 7'd2, 1, 15, -1, 0};
    tbl[7] = '{7'h05, 7'd1, 0, -1, -1, 0};
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N; i++) w[i] = tbl[v].base + W'(tbl[v].step * W'(i));
      do_load(w, tbl[v].gap, tbl[v].abort_k, tbl[v].restart_k, tbl[v].bad, lat);
    end

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < N; i++) w[i] = W'($urandom);
      do_load(w, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1,
              -1, $urandom_range(0, 3) == 0, lat);
    end

    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    cfg_valid = 1;
    for (int k = 0; k < 8; k++) begin
      cfg_data = W'(k + 1);
      @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    chk_reset("reset mid-load");
    rst = 0;
    cfg_valid = 0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
